rf_read_port_arb: RTL and testbench
===================================

// Module: rf_read_port_arb
// PURPOSE
//  Shares the limited register-file read ports among all issue-slot source-operand requesters.
//  Sits between the issue stage and the multiported regfile.
//  Picks up to NUM_PORTS distinct addresses per cycle using round-robin priority with starvation
//    override, merges same-address requests onto one port, and treats x0 reads as port-free zero.
//  Returns data to each granted requester one cycle later, matching the regfile's registered reads.
// PARAMETERS
//  NUM_REQ     6   requesters (ISSUE_WIDTH_MAX*NUM_SRCS)
//  NUM_PORTS   4   RF read ports (NUM_RF_R_PORTS), 1 <= NUM_PORTS <= NUM_REQ
//  SRC_LEN     5   register address width
//  DATA_LEN    32  register data width
//  STARVE_LIM  4   wait cycles after which a requester becomes urgent, >= 1
// PORTS
//  clk            in   1                    clock, all state on posedge
//  rst            in   1                    synchronous active-high reset
//  flush          in   1                    pipeline flush: drop in-flight responses
//  req_v          in   NUM_REQ              requester i has a pending read
//  req_addr       in   NUM_REQ x SRC_LEN    address for requester i
//  req_gnt        out  NUM_REQ              requester i is granted this cycle (combinational)
//  port_en        out  NUM_PORTS            read port p carries a valid address
//  port_addr      out  NUM_PORTS x SRC_LEN  address driven to RF read port p (0 when !port_en)
//  rf_r_port_data in   NUM_PORTS x DATA_LEN RF read data, valid the cycle after port_addr
//  rsp_v          out  NUM_REQ              response valid for requester i
//  rsp_data       out  NUM_REQ x DATA_LEN   read data for requester i
// BEHAVIOUR
//  Reset
//   - rr_ptr=0, all wait_cnt=0, rsp_v=0, rsp_data=0.
//   - Outputs follow from state/inputs, with no grants while rst=1.
//  Handshake
//   - Requester holds req_v/req_addr stable until req_gnt.
//   - Grant consumes the request; dropping req_v before grant is legal and clears its wait_cnt.
//  Priority order per cycle
//   1. Urgent requesters (wait_cnt==STARVE_LIM), in index order from rr_ptr.
//   2. Remaining requesters, round-robin from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
//  Port allocation
//   - Walk requesters in priority order.
//   - addr==0: granted with no port.
//   - addr equal to one already on an allocated port: granted and shares that port.
//   - Otherwise: takes the next free port (lowest index first) if one remains; else not granted.
//   - Unused ports: port_en=0, port_addr=0.
//  rr_ptr
//   - If any non-x0 grant occurred, becomes (highest-priority-order last granted index + 1) mod NUM_REQ.
//   - Otherwise unchanged.
//  wait_cnt[i]
//   - Increments (saturating at STARVE_LIM) when req_v[i] is high and not granted.
//   - Clears on grant or when !req_v[i].
//  Response (cycle N+1 for a grant in cycle N)
//   - rsp_v[i]=1.
//   - rsp_data[i]=rf_r_port_data[sel_q[i]], or 0 for x0.
//   - sel_q and an x0 flag are registered in cycle N.
//   - rsp_v is a single-cycle pulse.
//  flush
//   - In cycle N suppresses grants in N; rsp_v in N+1 is 0.
//   - flush in N+1 also forces rsp_v=0 that cycle.
//   - rr_ptr and wait_cnt are cleared.
//  rst mid-operation: responses for grants made before reset are never delivered.
//  Guarantee: with NUM_PORTS>=1, every continuously asserted request is granted within
//    NUM_REQ*(STARVE_LIM+1) cycles.
// TESTING
//  - 6 reqs, distinct nonzero addrs 1..6, rr_ptr=0:
//      gnt=001111, ports=1,2,3,4; next cycle gnt=110000, rsp_v follows one cycle after each grant.
//  - reqs 0,1,2 all addr 7:
//      one port used (port0=7), all three granted; rsp_data=RF[7] for all three next cycle.
//  - req 3 addr 0 plus 4 other distinct addrs:
//      all 5 granted; req 3 rsp_data=0; no port carries addr 0.
//  - reqs 0-3 held continuously, req 5 held continuously:
//      req 5 granted within STARVE_LIM+1 cycles; wait_cnt saturates at 4, never wraps.
//  - grant in cycle N, flush in cycle N+1:
//      rsp_v=0 in N+1, rr_ptr=0.
//  - rst asserted while responses are in flight:
//      rsp_v=0 next cycle, no stale data.

Source files
------------

// File: rtl/rf_read_port_arb.sv
// Register-file read-port arbiter: round-robin with starvation override,
// same-address port sharing, x0 reads served without a port.
module rf_read_port_arb #(
   parameter int NUM_REQ    = 6,
   parameter int NUM_PORTS  = 4,
   parameter int SRC_LEN    = 5,
   parameter int DATA_LEN   = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [NUM_REQ-1:0]                  req_v,
   input  logic [NUM_REQ-1:0][SRC_LEN-1:0]     req_addr,
   output logic [NUM_REQ-1:0]                  req_gnt,
   output logic [NUM_PORTS-1:0]                port_en,
   output logic [NUM_PORTS-1:0][SRC_LEN-1:0]   port_addr,
   input  logic [NUM_PORTS-1:0][DATA_LEN-1:0]  rf_r_port_data,
   output logic [NUM_REQ-1:0]                  rsp_v,
   output logic [NUM_REQ-1:0][DATA_LEN-1:0]    rsp_data
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(STARVE_LIM + 1);
   localparam int NW = $clog2(NUM_PORTS + 1);

   logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0][CW-1:0] wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0]         rsp_v_q, rsp_v_d;
   logic [NUM_REQ-1:0]         x0_q, x0_d;
   logic [NUM_REQ-1:0][PW-1:0] sel_q, sel_d;

   logic          act;
   logic [NW-1:0] used;
   logic          hit;
   logic [PW-1:0] hit_p;
   logic [IW-1:0] idx;
   logic          last_v;
   logic [IW-1:0] last_idx;

   assign act = !rst && !flush;

   // Pass 0 serves urgent requesters, pass 1 everyone else, both from rr_ptr.
   always_comb begin
      req_gnt   = '0;
      port_en   = '0;
      port_addr = '0;
      sel_d     = '0;
      x0_d      = '0;
      used      = '0;
      hit       = 1'b0;
      hit_p     = '0;
      idx       = '0;
      last_v    = 1'b0;
      last_idx  = '0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (act && req_v[idx] &&
                ((wait_cnt_q[idx] == CW'(STARVE_LIM)) == (pass == 0))) begin
               if (req_addr[idx] == '0) begin
                  req_gnt[idx] = 1'b1;
                  x0_d[idx]    = 1'b1;
               end else begin
                  hit   = 1'b0;
                  hit_p = '0;
                  for (int p = 0; p < NUM_PORTS; p++) begin
                     if (!hit && port_en[p] && port_addr[p] == req_addr[idx]) begin
                        hit   = 1'b1;
                        hit_p = PW'(p);
                     end
                  end
                  if (hit) begin
                     req_gnt[idx] = 1'b1;
                     sel_d[idx]   = hit_p;
                     last_v       = 1'b1;
                     last_idx     = idx;
                  end else if (int'(used) < NUM_PORTS) begin
                     port_en[PW'(used)]   = 1'b1;
                     port_addr[PW'(used)] = req_addr[idx];
                     sel_d[idx]           = PW'(used);
                     used                 = used + NW'(1);
                     req_gnt[idx]         = 1'b1;
                     last_v               = 1'b1;
                     last_idx             = idx;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (flush) begin
         rr_ptr_d = '0;
      end else if (last_v) begin
         rr_ptr_d = (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);
      end
      wait_cnt_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (flush || !req_v[i] || req_gnt[i]) begin
            wait_cnt_d[i] = '0;
         end else if (wait_cnt_q[i] < CW'(STARVE_LIM)) begin
            wait_cnt_d[i] = wait_cnt_q[i] + CW'(1);
         end else begin
            wait_cnt_d[i] = wait_cnt_q[i];
         end
      end
      rsp_v_d = req_gnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         wait_cnt_q <= '0;
         rsp_v_q    <= '0;
         x0_q       <= '0;
         sel_q      <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         rsp_v_q    <= rsp_v_d;
         x0_q       <= x0_d;
         sel_q      <= sel_d;
      end
   end

   // A flush or reset in the response cycle kills the in-flight data.
   assign rsp_v = (rst || flush) ? '0 : rsp_v_q;

   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_v[i] && !x0_q[i]) begin
            rsp_data[i] = rf_r_port_data[sel_q[i]];
         end
      end
   end

endmodule

// File: tb/tb_rf_read_port_arb.sv
// Bench for rf_read_port_arb: directed steps feed a response scoreboard
// that an independent negedge monitor drains.
module tb_rf_read_port_arb;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 flush = 1'b0;
   logic [5:0]           req_v = '0;
   logic [5:0][4:0]      req_addr = '0;
   logic [5:0]           req_gnt;
   logic [3:0]           port_en;
   logic [3:0][4:0]      port_addr;
   logic [3:0][31:0]     rf_data = '0;
   logic [5:0]           rsp_v;
   logic [5:0][31:0]     rsp_data;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   rf_read_port_arb dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .req_v(req_v),
      .req_addr(req_addr),
      .req_gnt(req_gnt),
      .port_en(port_en),
      .port_addr(port_addr),
      .rf_r_port_data(rf_data),
      .rsp_v(rsp_v),
      .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rfval(input logic [4:0] r);
      return 32'hC0DE_0000 + 32'h1111 * {27'd0, r};
   endfunction

   // Registered-read regfile model.
   always @(posedge clk) begin
      for (int p = 0; p < 4; p++) rf_data[p] <= rfval(port_addr[p]);
   end

   // Monitor: every presented response must match the queue head.
   always @(negedge clk) begin
      for (int i = 0; i < 6; i++) begin
         if (rsp_v[i]) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rsp_unexpected req=%0d data=%h required none", i, rsp_data[i]);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.idx != i || rsp_data[i] !== e.data) begin
                  fails++;
                  $display("FAIL rsp req=%0d data=%h required req=%0d data=%h",
                           i, rsp_data[i], e.idx, e.data);
               end
            end
         end
      end
   end

   task automatic step(input logic [5:0] v, input logic [5:0][4:0] a,
                       input logic fl, input logic r,
                       input logic [5:0] eg, input logic [3:0] een,
                       input logic [3:0][4:0] epa, input logic push,
                       input string name);
      @(posedge clk);
      #2;
      req_v = v;
      req_addr = a;
      flush = fl;
      rst = r;
      #1;
      tests++;
      if (req_gnt !== eg) begin
         fails++;
         $display("FAIL %s gnt=%b required %b", name, req_gnt, eg);
      end
      tests++;
      if (port_en !== een) begin
         fails++;
         $display("FAIL %s port_en=%b required %b", name, port_en, een);
      end
      tests++;
      if (port_addr !== epa) begin
         fails++;
         $display("FAIL %s port_addr=%h required %h", name, port_addr, epa);
      end
      if (push) begin
         for (int i = 0; i < 6; i++) begin
            if (eg[i]) q.push_back('{i, (a[i] == 5'd0) ? 32'd0 : rfval(a[i])});
         end
      end
   endtask

   task automatic chk_norsp(input string name);
      tests++;
      if (rsp_v !== 6'b0 || rsp_data !== '0) begin
         fails++;
         $display("FAIL %s rsp_v=%b data=%h required 0", name, rsp_v, rsp_data);
      end
   endtask

   localparam logic [5:0][4:0] A16  = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [3:0][4:0] P14  = {5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [5:0][4:0] A7   = {5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd7};
   localparam logic [5:0][4:0] AX0  = {5'd0, 5'd11, 5'd0, 5'd10, 5'd9, 5'd8};
   localparam logic [5:0][4:0] AST  = {5'd1, 5'd9, 5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [5:0][4:0] AZ   = '0;
   localparam logic [3:0][4:0] PZ   = '0;

   initial begin
      step(6'h3F, A16, 0, 1, 6'b0, 4'b0, PZ, 0, "reset_gnt");
      chk_norsp("reset_rsp");
      step(6'h3F, A16, 0, 1, 6'b0, 4'b0, PZ, 0, "reset_gnt2");
      chk_norsp("reset_rsp2");

      step(6'b111111, A16, 0, 0, 6'b001111, 4'b1111, P14, 1, "rr_first");
      step(6'b110000, A16, 0, 0, 6'b110000, 4'b0011,
           {5'd0, 5'd0, 5'd6, 5'd5}, 1, "rr_second");
      step(6'b0, AZ, 0, 0, 6'b0, 4'b0, PZ, 0, "idle1");

      step(6'b000111, A7, 0, 0, 6'b000111, 4'b0001,
           {5'd0, 5'd0, 5'd0, 5'd7}, 1, "share_addr7");
      step(6'b0, AZ, 0, 0, 6'b0, 4'b0, PZ, 0, "idle2");

      step(6'b011111, AX0, 0, 0, 6'b011111, 4'b1111,
           {5'd10, 5'd9, 5'd8, 5'd11}, 1, "x0_no_port");
      step(6'b0, AZ, 0, 0, 6'b0, 4'b0, PZ, 0, "idle3");
      step(6'b0, AZ, 1, 0, 6'b0, 4'b0, PZ, 0, "flush_clear");

      for (int c = 1; c <= 4; c++)
         step(6'b111111, AST, 0, 0, 6'b101111, 4'b1111, P14, 1, "starve_wait");
      step(6'b111111, AST, 0, 0, 6'b110111, 4'b1111,
           {5'd3, 5'd2, 5'd1, 5'd9}, 1, "starve_urgent");

      step(6'b000100, {5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0}, 0, 0,
           6'b000100, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd12}, 0, "flush_pre");
      step(6'b111111, A16, 1, 0, 6'b0, 4'b0, PZ, 0, "flush_gnt");
      chk_norsp("flush_rsp");
      step(6'b111111, A16, 0, 0, 6'b001111, 4'b1111, P14, 1, "flush_rr0");
      step(6'b110000, A16, 0, 0, 6'b110000, 4'b0011,
           {5'd0, 5'd0, 5'd6, 5'd5}, 1, "flush_rr_next");

      step(6'b000011, {5'd0, 5'd0, 5'd0, 5'd0, 5'd14, 5'd13}, 0, 0,
           6'b000011, 4'b0011, {5'd0, 5'd0, 5'd14, 5'd13}, 0, "rst_pre");
      step(6'b0, AZ, 0, 1, 6'b0, 4'b0, PZ, 0, "rst_mid");
      chk_norsp("rst_mid_rsp");
      step(6'b0, AZ, 0, 0, 6'b0, 4'b0, PZ, 0, "rst_after");
      chk_norsp("rst_after_rsp");
      step(6'b111111, A16, 0, 0, 6'b001111, 4'b1111, P14, 1, "rst_rr0");
      step(6'b0, AZ, 0, 0, 6'b0, 4'b0, PZ, 0, "idle4");
      step(6'b0, AZ, 0, 0, 6'b0, 4'b0, PZ, 0, "idle5");
      @(posedge clk);

      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain pending=%0d required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
